// File: rtl/ccff_chain_loader.sv
// Programming-side driver for one tile's configuration flip-flop chain: serialises
// bitstream words MSB-first onto ccff_head and returns the displaced tail bits as readback words.
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 12,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
);

    localparam int                NB_W        = $clog2(WORD_W + 1);
    localparam logic [NB_W-1:0]   WORD_NB     = NB_W'(WORD_W);
    localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  WORD_W_C    = CNT_W'(WORD_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_RBACK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WORD_W-1:0]  r_sreg;
    logic [WORD_W-1:0]  r_rb_sreg;
    logic [WORD_W-1:0]  w_rb_sreg_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_remain;
    logic [NB_W-1:0]    r_nbits;
    logic [NB_W-1:0]    r_scnt;
    logic [NB_W-1:0]    w_nbits;
    logic               w_accept;
    logic               r_head;
    logic               r_shift_en;
    logic               r_word_ready;
    logic               r_rb_valid;
    logic [WORD_W-1:0]  r_rb_data;
    logic               r_busy;
    logic               r_done;

    // Readback collects tail bits LSB-side; a short final word is moved up to the MSB end.
    function automatic logic [WORD_W-1:0] f_left_align(input logic [WORD_W-1:0] v,
                                                       input logic [NB_W-1:0]   n);
        logic [NB_W-1:0] amt;
        amt = WORD_NB - n;
        return v << amt;
    endfunction

    assign w_remain      = CHAIN_LEN_C - r_bit_cnt;
    assign w_nbits       = (w_remain > WORD_W_C) ? WORD_NB : NB_W'(w_remain);
    assign w_accept      = (r_state == ST_FETCH) && word_valid && !abort;
    assign w_rb_sreg_nxt = {r_rb_sreg[WORD_W-2:0], ccff_tail};

    // State register.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort overrides every transition.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_next_state = ST_FETCH;
                    else       w_next_state = ST_IDLE;
                end
                ST_FETCH: begin
                    if (word_valid) w_next_state = ST_SHIFT;
                    else            w_next_state = ST_FETCH;
                end
                ST_SHIFT: begin
                    if (r_scnt == NB_W'(1)) w_next_state = ST_RBACK;
                    else                    w_next_state = ST_SHIFT;
                end
                ST_RBACK: begin
                    if (!rb_ready)                      w_next_state = ST_RBACK;
                    else if (r_bit_cnt == CHAIN_LEN_C)  w_next_state = ST_DONE;
                    else                                w_next_state = ST_FETCH;
                end
                ST_DONE:  w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Word/readback shift registers and bit counters.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_sreg    <= {WORD_W{1'b0}};
            r_rb_sreg <= {WORD_W{1'b0}};
            r_bit_cnt <= {CNT_W{1'b0}};
            r_nbits   <= {NB_W{1'b0}};
            r_scnt    <= {NB_W{1'b0}};
        end else if ((r_state == ST_IDLE) && start && !abort) begin
            r_bit_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_sreg    <= word_data;
            r_rb_sreg <= {WORD_W{1'b0}};
            r_nbits   <= w_nbits;
            r_scnt    <= w_nbits;
        end else if (r_state == ST_SHIFT) begin
            // The chain shifts on this edge even when aborting, so the counters track it.
            r_sreg    <= r_sreg << 1;
            r_rb_sreg <= w_rb_sreg_nxt;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_scnt    <= r_scnt - NB_W'(1);
        end else begin
            r_sreg    <= r_sreg;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_shift_en   <= 1'b0;
            r_word_ready <= 1'b0;
            r_rb_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_shift_en   <= (w_next_state == ST_SHIFT);
            r_word_ready <= (w_next_state == ST_FETCH);
            r_rb_valid   <= (w_next_state == ST_RBACK);
            r_busy       <= (w_next_state != ST_IDLE);
            r_done       <= (w_next_state == ST_DONE);
        end
    end

    // Head bit mirrors the word MSB during SHIFT and holds its last value elsewhere.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_head <= 1'b0;
        end else if (w_accept) begin
            r_head <= word_data[WORD_W-1];
        end else if ((r_state == ST_SHIFT) && (w_next_state == ST_SHIFT)) begin
            r_head <= r_sreg[WORD_W-2];
        end else begin
            r_head <= r_head;
        end
    end

    // Readback word captured on the last shift edge, including the tail bit sampled there.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_rb_data <= {WORD_W{1'b0}};
        end else if ((r_state == ST_SHIFT) && (w_next_state == ST_RBACK)) begin
            r_rb_data <= f_left_align(w_rb_sreg_nxt, r_nbits);
        end else begin
            r_rb_data <= r_rb_data;
        end
    end

    assign word_ready    = r_word_ready;
    assign rb_data       = r_rb_data;
    assign rb_valid      = r_rb_valid;
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
